// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//
// Purpose:
//   Frame controller for a UART transmitter. Sequences START, DATA, optional
//   PARITY and STOP on the serial line. The payload bits come from an external
//   serializer, which this block enables through ser_en. A new word is accepted
//   in IDLE, or in the STOP cycle so that frames can run back to back with no
//   gap between them.
//
// Configuration:
//   UART_TX_PARITY_EN - when defined, the PARITY state and parity generation
//                       are built. When undefined, DATA always exits to STOP
//                       and PAR_EN / PAR_TYP are ignored.
//
// Parameters:
//   DATAWIDTH  - payload width in bits (default 8)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active low
//   P_DATA     in   payload word, captured on acceptance
//   Data_Valid in   transmit request
//   PAR_EN     in   1 = append a parity bit (captured on acceptance)
//   PAR_TYP    in   0 = even parity, 1 = odd parity (captured on acceptance)
//   ser_data   in   current payload bit from the serializer
//   ser_done   in   serializer is presenting its last payload bit
//   ser_en     out  serializer shift enable
//   TX_OUT     out  serial line, idle high
//   busy       out  high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] P_DATA,
    input  logic                 Data_Valid,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    input  logic                 ser_data,
    input  logic                 ser_done,
    output logic                 ser_en,
    output logic                 TX_OUT,
    output logic                 busy
);

    localparam int CNT_W = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATAWIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]       state_q,   state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             accept;

    // A word is taken only while idle or during the STOP cycle. The STOP
    // window is what makes consecutive frames contiguous.
    assign accept = Data_Valid && ((state_q == IDLE) || (state_q == STOP));

`ifdef UART_TX_PARITY_EN
    logic [DATAWIDTH-1:0] data_q;
    logic                 par_en_q;
    logic                 par_typ_q;
    logic                 parity_bit;

    // Parity comes from the captured word, so input changes mid-frame have
    // no effect on the bit that is sent.
    assign parity_bit = (^data_q) ^ par_typ_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (accept) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end
`else
    // Parity is not built. These ports remain for pin compatibility and are
    // collected here on purpose.
    logic unused_parity_inputs;
    assign unused_parity_inputs = ^{P_DATA, PAR_EN, PAR_TYP};
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = START;
            end
            START: begin
                state_d   = DATA;
                bit_cnt_d = '0;
            end
            DATA: begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                // The counter is a backstop: DATA never outlasts DATAWIDTH
                // cycles, even if the serializer never raises ser_done.
                if (ser_done || (bit_cnt_q == LAST_BIT)) begin
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    state_d   = par_en_q ? PARITY : STOP;
`else
                    state_d   = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                state_d = STOP;
            end
`endif
            STOP: begin
                state_d = accept ? START : IDLE;
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Outputs are decoded from registered state only. The one exception is
    // TX_OUT in DATA, which passes the serializer bit straight through.
    always_comb begin
        TX_OUT = 1'b1;
        busy   = 1'b0;
        ser_en = 1'b0;
        case (state_q)
            START: begin
                TX_OUT = 1'b0;
                busy   = 1'b1;
                ser_en = 1'b1;
            end
            DATA: begin
                TX_OUT = ser_data;
                busy   = 1'b1;
                ser_en = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                TX_OUT = parity_bit;
                busy   = 1'b1;
            end
`endif
            STOP: begin
                busy   = 1'b1;
            end
            default: begin
                TX_OUT = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
//
// Randomized and directed stimulus for uart_tx_ctrl. A frame-level reference
// model expands every accepted word into the expected sequence of line cycles
// (START, payload bits, optional parity, STOP), and the outputs are compared
// against that sequence one cycle at a time. The model also provides the
// serializer: in each DATA cycle it drives the matching payload bit on
// ser_data and raises ser_done on the last bit.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    localparam int W = 8;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    localparam int K_IDLE  = 0;
    localparam int K_START = 1;
    localparam int K_DATA  = 2;
    localparam int K_PAR   = 3;
    localparam int K_STOP  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] P_DATA;
    logic         Data_Valid;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic         ser_data;
    logic         ser_done;
    logic         ser_en;
    logic         TX_OUT;
    logic         busy;

    uart_tx_ctrl #(.DATAWIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   kind;
        logic tx;
        logic done;
    } cyc_t;

    cyc_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    frames = 0;
    string scen   = "reset";

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h at %0t", scen, tag, got, exp, $time);
        end
    endtask

    // Expand one accepted word into the cycles it should put on the line.
    task automatic push_frame(input logic [W-1:0] d, input logic pen, input logic ptyp,
                              input bit use_done);
        cyc_t c;
        int   len;
        logic par;
        par    = 1'b0;
        c.kind = K_START; c.tx = 1'b0; c.done = 1'b0;
        exp_q.push_back(c);
        for (int i = 0; i < W; i++) begin
            c.kind = K_DATA;
            c.tx   = d[i];
            c.done = use_done && (i == W - 1);
            exp_q.push_back(c);
        end
        len = W + 2;
        if (PAR_BUILT && pen) begin
            // Even parity makes the number of ones, parity included, even.
            par = 1'b0;
            for (int i = 0; i < W; i++) if (d[i]) par = ~par;
            if (ptyp) par = ~par;
            c.kind = K_PAR; c.tx = par; c.done = 1'b0;
            exp_q.push_back(c);
            len++;
        end
        c.kind = K_STOP; c.tx = 1'b1; c.done = 1'b0;
        exp_q.push_back(c);
        frames++;
        $display("[%s] frame %0d accepted: data=%02h par_en=%0b par_typ=%0b ser_done=%0b len=%0d parity=%0b",
                 scen, frames, d, pen, ptyp, use_done, len, par);
    endtask

    // One clock cycle. Call it at posedge+1; it returns at the next posedge+1.
    task automatic run_cycle(input logic dv, input logic [W-1:0] d, input logic pen,
                             input logic ptyp, input bit use_done);
        cyc_t cur;
        bit   have;
        bit   acc;
        have = (exp_q.size() != 0);
        if (have) cur = exp_q[0];
        else begin
            cur.kind = K_IDLE; cur.tx = 1'b1; cur.done = 1'b0;
        end
        Data_Valid = dv;
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        if (cur.kind == K_DATA) begin
            ser_data = cur.tx;
            ser_done = cur.done;
        end else begin
            ser_data = 1'($urandom);
            ser_done = 1'($urandom);
        end
        @(negedge clk);
        check_eq("tx_out", 32'(TX_OUT), 32'(cur.tx));
        check_eq("busy",   32'(busy),   32'(cur.kind != K_IDLE));
        check_eq("ser_en", 32'(ser_en), 32'((cur.kind == K_START) || (cur.kind == K_DATA)));
        acc = dv && ((cur.kind == K_IDLE) || (cur.kind == K_STOP));
        if (have) void'(exp_q.pop_front());
        if (acc) push_frame(d, pen, ptyp, use_done);
        @(posedge clk);
        #1;
    endtask

    // No new request. The other inputs change at random so that mid-frame
    // changes are exercised.
    task automatic idle(input int n);
        repeat (n) run_cycle(1'b0, W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    endtask

    initial begin
        rst        = 1'b0;
        Data_Valid = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        ser_data   = 1'b0;
        ser_done   = 1'b0;

        #2;
        check_eq("rst_tx",     32'(TX_OUT), 32'd1);
        check_eq("rst_busy",   32'(busy),   32'd0);
        check_eq("rst_ser_en", 32'(ser_en), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        scen = "single_a5";
        run_cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        idle(W + 3);

        scen = "parity_even_07";
        run_cycle(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        idle(W + 4);
        scen = "parity_odd_07";
        run_cycle(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        idle(W + 4);

        // Data_Valid stays high. 8'hAA is presented during frame one and is
        // taken only in its STOP cycle.
        scen = "back_to_back";
        run_cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        repeat (W + 2) run_cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        idle(W + 4);

        scen = "dv_in_data";
        run_cycle(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
        idle(3);
        run_cycle(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
        idle(W + 4);

        scen = "no_ser_done";
        run_cycle(1'b1, 8'h96, 1'b1, 1'b0, 1'b0);
        idle(W + 4);

        scen = "par_en_ff";
        run_cycle(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        idle(W + 4);

        // Reset in the 4th DATA cycle. Payload bit 3 of 8'h5A is 1, so
        // ser_data is driven to 0 to make an unreset line visible.
        scen = "reset_mid_data";
        run_cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        idle(4);
        ser_data   = 1'b0;
        ser_done   = 1'b0;
        Data_Valid = 1'b1;
        rst        = 1'b0;
        #1;
        check_eq("tx_now",     32'(TX_OUT), 32'd1);
        check_eq("busy_now",   32'(busy),   32'd0);
        check_eq("ser_en_now", 32'(ser_en), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check_eq("tx_held",   32'(TX_OUT), 32'd1);
        check_eq("busy_held", 32'(busy),   32'd0);
        Data_Valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle(1);
        scen = "after_reset";
        run_cycle(1'b1, 8'h81, 1'b1, 1'b1, 1'b1);
        idle(W + 4);

        scen = "random";
        repeat (600) begin
            run_cycle(1'($urandom_range(0, 3) == 0), W'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        idle(W + 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
